// File: rtl/code_conv_scheduler.sv
// Round-robin scheduler sharing one registered binary/Gray converter among N_REQ requesters.
// Optional completion counters are built when CODE_CONV_STATS_EN is defined.
module code_conv_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_mode,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_mode,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [15:0]            stat_b2g,
    output logic [15:0]            stat_g2b
);

    // state | meaning
    // IDLE  | arbitrate; accept one request per cycle
    // CONV  | convert operand registers into the response registers
    // RESP  | hold response until rsp_ready
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_found;
    logic [ID_W-1:0]  op_id;
    logic             op_mode;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] conv_data;

    // Search starts one past the previous winner so it drops to lowest priority.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant) + k) % N_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    assign req_ready = (!rst && state == ST_IDLE && grant_found)
                       ? (N_REQ'(1) << grant_idx) : '0;

    always_comb begin
        conv_data            = '0;
        conv_data[WIDTH-1]   = op_data[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            conv_data[i] = op_mode ? (conv_data[i+1] ^ op_data[i])
                                   : (op_data[i+1] ^ op_data[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            op_id      <= '0;
            op_mode    <= 1'b0;
            op_data    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_mode   <= 1'b0;
            rsp_data   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        op_id      <= grant_idx;
                        op_mode    <= req_mode[grant_idx];
                        op_data    <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                        last_grant <= grant_idx;
                        state      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    rsp_data  <= conv_data;
                    rsp_id    <= op_id;
                    rsp_mode  <= op_mode;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CODE_CONV_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_b2g <= '0;
            stat_g2b <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (!rsp_mode && stat_b2g != 16'hFFFF) stat_b2g <= stat_b2g + 16'd1;
            if (rsp_mode && stat_g2b != 16'hFFFF)  stat_g2b <= stat_g2b + 16'd1;
        end
    end
`else
    assign stat_b2g = '0;
    assign stat_g2b = '0;
`endif

endmodule

// File: tb/tb_code_conv_scheduler.sv
// Randomized and directed bench for code_conv_scheduler against a transaction-level model.
// Define CODE_CONV_STATS_EN for both files to check the counter build.
module tb_code_conv_scheduler;

    localparam int N = 4;
    localparam int W = 4;
`ifdef CODE_CONV_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_mode;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic           rsp_mode;
    logic [W-1:0]   rsp_data;
    logic [15:0]    stat_b2g;
    logic [15:0]    stat_g2b;

    code_conv_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_mode(rsp_mode), .rsp_data(rsp_data),
        .stat_b2g(stat_b2g), .stat_g2b(stat_g2b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // transaction-level model: 0 idle, 1 converting, 2 response pending
    int         m_phase;
    int         m_ptr;
    int         exp_id;
    bit         exp_mode;
    logic [3:0] exp_data;
    int         cnt_b2g, cnt_g2b;
    int         cyc = 0;
    int         grant_id[$];
    int         grant_cyc[$];
    bit         rsp_hs_seen;
    logic [3:0] last_rsp_data;
    int         last_rsp_id;
    bit         auto_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] from_gray(input logic [3:0] g);
        logic [3:0] b;
        b = g;
        for (int s = 1; s < W; s = s * 2) b = b ^ (b >> s);
        return b;
    endfunction

    // Inputs must already be driven (at posedge+1); ends at the next posedge+1.
    task automatic cycle();
        int         g;
        int         idx;
        logic [3:0] exp_rdy;
        logic [3:0] d;
        #1;
        g = -1;
        if (m_phase == 0 && !rst) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, (m_phase == 2));
        if (m_phase == 2) begin
            check("rsp_id", rsp_id, exp_id);
            check("rsp_mode", rsp_mode, exp_mode);
            check("rsp_data", rsp_data, exp_data);
        end
        check("stat_b2g", stat_b2g, STATS_EN ? cnt_b2g : 0);
        check("stat_g2b", stat_g2b, STATS_EN ? cnt_g2b : 0);
        if (rst) begin
            m_phase = 0;
            m_ptr   = N - 1;
            cnt_b2g = 0;
            cnt_g2b = 0;
        end else if (m_phase == 0) begin
            if (g >= 0) begin
                m_ptr    = g;
                m_phase  = 1;
                exp_id   = g;
                exp_mode = req_mode[g];
                d        = req_data[g*W +: W];
                exp_data = exp_mode ? from_gray(d) : to_gray(d);
                grant_id.push_back(g);
                grant_cyc.push_back(cyc);
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
            if (exp_mode) cnt_g2b++; else cnt_b2g++;
            rsp_hs_seen   = 1'b1;
            last_rsp_data = rsp_data;
            last_rsp_id   = rsp_id;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (auto_drop && g >= 0 && !rst) req_valid[g] = 1'b0;
    endtask

    task automatic do_req(input int id, input bit mode, input logic [3:0] d);
        int n;
        req_mode[id]       = mode;
        req_data[id*W +: W] = d;
        req_valid[id]      = 1'b1;
        rsp_ready          = 1'b1;
        auto_drop          = 1'b1;
        rsp_hs_seen        = 1'b0;
        n = 0;
        while (!rsp_hs_seen && n < 20) begin
            cycle();
            n++;
        end
        if (!rsp_hs_seen) check("rsp_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (m_phase != 0 && n < 10) begin
            cycle();
            n++;
        end
        if (m_phase != 0) check("drain_timeout", 0, 1);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (m_phase != 2 && n < 10) begin
            cycle();
            n++;
        end
        if (m_phase != 2) check("resp_timeout", 0, 1);
    endtask

    initial begin
        logic [3:0] tmp;
        int         bp_id;
        rst       = 1'b1;
        req_valid = '1;
        req_mode  = 4'b0101;
        req_data  = 16'hA5C3;
        rsp_ready = 1'b1;
        auto_drop = 1'b0;
        cnt_b2g   = 0;
        cnt_g2b   = 0;
        @(posedge clk);
        #1;
        m_phase = 0;
        m_ptr   = N - 1;
        cycle();
        cycle();
        rst = 1'b0;
        grant_id.delete();
        cycle();
        if (grant_id.size() > 0) check("first_grant", grant_id[0], 0);
        else check("first_grant_missing", 0, 1);
        drain();

        do_req(1, 1'b0, 4'b1011);
        check("b2g_1011", last_rsp_data, 4'b1110);
        check("b2g_1011_id", last_rsp_id, 1);
        do_req(1, 1'b0, 4'b0111);
        check("b2g_0111", last_rsp_data, 4'b0100);
        do_req(2, 1'b1, 4'b1110);
        check("g2b_1110", last_rsp_data, 4'b1011);
        check("g2b_1110_id", last_rsp_id, 2);
        do_req(2, 1'b1, 4'b1000);
        check("g2b_1000", last_rsp_data, 4'b1111);

        for (int v = 0; v < 16; v++) begin
            do_req(v % N, 1'b0, 4'(v));
            tmp = last_rsp_data;
            do_req((v + 1) % N, 1'b1, tmp);
            check("roundtrip_b2g", last_rsp_data, v);
            do_req((v + 2) % N, 1'b1, 4'(v));
            tmp = last_rsp_data;
            do_req((v + 3) % N, 1'b0, tmp);
            check("roundtrip_g2b", last_rsp_data, v);
        end

        // round-robin from a fresh reset with all requesters busy
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grant_id.delete();
        grant_cyc.delete();
        auto_drop = 1'b0;
        req_data  = 16'h3C96;
        req_mode  = 4'b1010;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 13; i++) cycle();
        if (grant_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("rr_order", grant_id[i], i % N);
                if (i > 0) check("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
            end
        end else check("rr_grant_count", grant_id.size(), 5);
        drain();

        // back-pressure
        req_valid = '1;
        rsp_ready = 1'b0;
        wait_resp();
        bp_id = m_ptr;
        for (int i = 0; i < 5; i++) cycle();
        rsp_ready = 1'b1;
        cycle();
        grant_id.delete();
        cycle();
        if (grant_id.size() > 0) check("bp_next_grant", grant_id[0], (bp_id + 1) % N);
        else check("bp_next_grant_missing", 0, 1);
        drain();

        // reset while a response is pending
        auto_drop    = 1'b1;
        req_valid[0] = 1'b1;
        rsp_ready    = 1'b0;
        wait_resp();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midop_rsp_valid", rsp_valid, 0);
        cycle();
        drain();

        do_req(0, 1'b0, 4'h3);
        do_req(1, 1'b1, 4'h9);
        do_req(2, 1'b0, 4'hC);
        do_req(3, 1'b1, 4'h6);
        do_req(0, 1'b0, 4'hF);
        cycle();
        check("stats_b2g_3", stat_b2g, STATS_EN ? 3 : 0);
        check("stats_g2b_2", stat_g2b, STATS_EN ? 2 : 0);

        // random traffic with drops and back-pressure
        auto_drop = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(2) == 0) begin
                        req_valid[i]       = 1'b1;
                        req_mode[i]        = 1'($urandom_range(1));
                        req_data[i*W +: W] = 4'($urandom_range(15));
                    end
                end else if ($urandom_range(15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = 1'($urandom_range(1));
            cycle();
        end
        drain();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
